uart_rx_frame: RTL
==================

# uart_rx_frame

Receive-side UART framer paired with the transmitter and its parity calculator. Oversamples the serial line and detects a start bit. Shifts in DATA_SIZE data bits LSB first, optionally checks an even or odd parity bit, and checks the stop bit. Delivers each good byte with a one-cycle valid strobe and flags parity and stop errors.

## Interface
- DATA_SIZE, 8, data bits per frame
- CLK_RX  input  1  system clock; all logic on rising edge
- RST_RX  input  1  reset, synchronous, active-high
- RX_IN  input  1  serial line, idle high
- PAR_EN  input  1  1 = parity bit present between data and stop
- PAR_TYP  input  1  1 = odd parity, 0 = even parity (same encoding as TX)
- Prescale  input  6  oversampling ratio in clocks per bit; legal values 8, 16, 32
- P_DATA  output  DATA_SIZE  last good received word
- Data_valid  output  1  one-cycle strobe, P_DATA is new
- par_err  output  1  one-cycle strobe, parity mismatch in the frame just ended
- stp_err  output  1  one-cycle strobe, stop bit sampled low

## Operation
- Reset (RST_RX=1 at a clock edge) sets state IDLE, all counters 0, P_DATA=0, Data_valid=0, par_err=0, stp_err=0.
- edge_cnt counts 0..Prescale-1 within a bit. bit_cnt counts data bits 0..DATA_SIZE-1.
- Sampling uses a majority vote of RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The voted value is valid from edge_cnt = Prescale/2+2.
- States and transitions:
  - IDLE: when RX_IN=0, go to START with edge_cnt=0. Prescale and PAR_EN/PAR_TYP are captured here and held for the frame.
  - START: at edge_cnt = Prescale-1, go to DATA if the voted bit is 0. If it is 1 (glitch), go to IDLE with no strobes.
  - DATA: at each edge_cnt = Prescale-1, shift the voted bit into shift[bit_cnt] (LSB first). After bit DATA_SIZE-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: expected parity is ^shift for even and ~^shift for odd. At edge_cnt = Prescale-1, record a mismatch and go to STOP.
  - STOP: at edge_cnt = Prescale-1, go to IDLE and evaluate the frame. If stop=1 and there is no parity mismatch, P_DATA<=shift and Data_valid=1. Otherwise par_err and/or stp_err =1, Data_valid=0, and P_DATA is held.
- P_DATA holds its value until the next good frame.
- Illegal Prescale values give undefined behaviour; no protection logic.

## Timing
- Strobes are registered and assert on the cycle after the STOP bit's edge_cnt = Prescale-1 edge. Each strobe is high for exactly one cycle.
- Frame length is (1+DATA_SIZE+PAR_EN+1)·Prescale clocks from the first low sample to the end of stop.
- Back-to-back frames: in IDLE the next start can be detected on the cycle the strobes assert. No dead cycle is required.
- par_err and stp_err can assert in the same cycle.
- RX_IN falling mid-STOP is ignored until IDLE.
- Reset mid-frame aborts the frame and emits no strobes. The next cycle is IDLE.
- Changes to PAR_EN, PAR_TYP or Prescale while not IDLE do not affect the frame in progress.

## Configuration
- UART_RX_SYNC_EN defined: RX_IN passes through a two-flop synchronizer reset to 1. All internal sampling uses the synchronized signal, and every output occurs 2 cycles later than stated above.
- UART_RX_SYNC_EN undefined: RX_IN is used directly. The source must already be synchronous to CLK_RX.

## Test plan
- Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity 0 and stop 1 -> Data_valid pulses once, P_DATA=0xA5, par_err=0, stp_err=0. The strobe lands 88 clocks after the start edge, plus 2 with UART_RX_SYNC_EN.
- Prescale=16, PAR_EN=1, PAR_TYP=1, send 0x3C with parity 0 (wrong; odd requires 1) -> par_err=1 for one cycle, Data_valid=0, P_DATA unchanged.
- Prescale=32, PAR_EN=0, send 0x81 with stop bit 0 -> stp_err=1, Data_valid=0. Then send 0x7E correctly -> P_DATA=0x7E.
- Line low for 3 clocks then high, Prescale=8 -> no strobes, state returns to IDLE. A following valid 0x55 frame is received correctly.
- Two frames 0x12 and 0x34 back to back, PAR_EN=0, Prescale=8 -> two Data_valid pulses exactly 80 clocks apart, with the correct data each time.
- RST_RX asserted mid-DATA of 0xFF -> no strobes, outputs at reset values. A following 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Oversampling UART receive framer: start detect, majority vote, parity/stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a two-flop synchronizer first.
module uart_rx_frame #(
   parameter int DATA_SIZE = 8
) (
   input  logic                 CLK_RX,
   input  logic                 RST_RX,
   input  logic                 RX_IN,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   input  logic [5:0]           Prescale,
   output logic [DATA_SIZE-1:0] P_DATA,
   output logic                 Data_valid,
   output logic                 par_err,
   output logic                 stp_err
);

   localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state;
   state_t               state_n;
   logic                 rx;
   logic [5:0]           edge_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_SIZE-1:0] shift;
   logic [2:0]           samp;
   logic [5:0]           ps_q;
   logic                 pe_q;
   logic                 pt_q;
   logic                 par_bad;
   logic                 start_frame;
   logic                 done;
   logic                 last;
   logic                 vote;
   logic                 exp_par;
   logic [5:0]           half;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge CLK_RX) begin
      if (RST_RX) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], RX_IN};
   end

   assign rx = sync_q[1];
`else
   assign rx = RX_IN;
`endif

   assign half    = {1'b0, ps_q[5:1]};
   assign last    = (edge_cnt == ps_q - 6'd1);
   assign vote    = (samp[0] & samp[1]) | (samp[0] & samp[2]) |
                    (samp[1] & samp[2]);
   assign exp_par = pt_q ? ~^shift : ^shift;

   // The last STOP clock already sees the next bit period, so a low line
   // there starts the next frame with no idle gap.
   always_comb begin
      state_n     = state;
      start_frame = 1'b0;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx) begin
               state_n     = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (last) state_n = vote ? IDLE : DATA;
         end
         DATA: begin
            if (last && bit_cnt == LAST_BIT)
               state_n = pe_q ? PARITY : STOP;
         end
         PARITY: begin
            if (last) state_n = STOP;
         end
         STOP: begin
            if (last) begin
               done = 1'b1;
               if (!rx) begin
                  state_n     = START;
                  start_frame = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_RX) begin
      if (RST_RX) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         samp       <= '0;
         ps_q       <= '0;
         pe_q       <= 1'b0;
         pt_q       <= 1'b0;
         par_bad    <= 1'b0;
         P_DATA     <= '0;
         Data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         state      <= state_n;
         Data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         if (start_frame) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            ps_q     <= Prescale;
            pe_q     <= PAR_EN;
            pt_q     <= PAR_TYP;
         end else if (state != IDLE) begin
            edge_cnt <= last ? 6'd0 : edge_cnt + 6'd1;
         end

         if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) samp[0] <= rx;
            if (edge_cnt == half)        samp[1] <= rx;
            if (edge_cnt == half + 6'd1) samp[2] <= rx;
         end

         if (state == DATA && last) begin
            shift[bit_cnt] <= vote;
            bit_cnt        <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end

         if (state == PARITY && last)
            par_bad <= (vote != exp_par);

         if (done) begin
            if (vote && !par_bad) begin
               P_DATA     <= shift;
               Data_valid <= 1'b1;
            end else begin
               par_err <= par_bad;
               stp_err <= !vote;
            end
         end
      end
   end

endmodule
